// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - game sequencer for the ball/brick engine.
// Generates the phase code, level, step period, launch angle and lives from the buttons and engine flags.
module game_flow_ctrl #(
  parameter int LIVES        = 3,
  parameter int MAX_LEVEL    = 2,
  parameter int PERIOD_BASE  = 200000,
  parameter int PERIOD_STEP  = 40000,
  parameter int PERIOD_MIN   = 16,
  parameter int LOAD_CYCLES  = 2,
  parameter int PAUSE_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_launch,
  input  logic        dead,
  input  logic        win,
  output logic [2:0]  state,
  output logic [2:0]  level,
  output logic [19:0] period,
  output logic [2:0]  angle,
  output logic [1:0]  lives
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_AIM   = 3'd2,
    S_RUN   = 3'd3,
    S_LOST  = 3'd4,
    S_WON   = 3'd5,
    S_OVER  = 3'd6,
    S_CLEAR = 3'd7
  } state_t;

  localparam logic [1:0]  LIVES_INIT = 2'(LIVES);
  localparam logic [2:0]  LEVEL_MAX  = 3'(MAX_LEVEL);
  localparam logic [31:0] LOAD_LAST  = 32'(LOAD_CYCLES - 1);
  localparam logic [31:0] PAUSE_LAST = 32'(PAUSE_CYCLES - 1);

  state_t      st, st_nxt;
  logic [2:0]  level_nxt;
  logic [1:0]  lives_nxt;
  logic [19:0] period_nxt;
  logic [2:0]  angle_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic        start_q, launch_q, fr;
  logic        start_edge, launch_edge;

  // Signed 32-bit arithmetic so a level that would drive the period negative clamps too.
  function automatic logic [19:0] calc_period(input logic [2:0] lvl);
    int p;
    p = PERIOD_BASE - int'(lvl) * PERIOD_STEP;
    if (p < PERIOD_MIN) p = PERIOD_MIN;
    return 20'(p);
  endfunction

  assign start_edge  = btn_start & ~start_q;
  assign launch_edge = btn_launch & ~launch_q;
  assign state       = st;

  always_comb begin
    st_nxt     = st;
    level_nxt  = level;
    lives_nxt  = lives;
    period_nxt = period;
    angle_nxt  = angle;
    cnt_nxt    = cnt;
    case (st)
      S_IDLE, S_OVER, S_CLEAR: begin
        if (start_edge) begin
          st_nxt    = S_LOAD;
          level_nxt = 3'd0;
          lives_nxt = LIVES_INIT;
        end
      end
      S_LOAD: if (cnt == LOAD_LAST) st_nxt = S_AIM;
      S_AIM:  if (launch_edge) st_nxt = S_RUN;
      S_RUN: begin
        if (win) begin
          st_nxt = S_WON;
        end else if (dead) begin
          if (lives > 2'd1) begin
            st_nxt    = S_LOST;
            lives_nxt = lives - 2'd1;
          end else begin
            st_nxt    = S_OVER;
            lives_nxt = 2'd0;
          end
        end
      end
      S_LOST: if (cnt == PAUSE_LAST) st_nxt = S_AIM;
      S_WON: begin
        if (cnt == PAUSE_LAST) begin
          if (level < LEVEL_MAX) begin
            level_nxt = level + 3'd1;
            st_nxt    = S_LOAD;
          end else begin
            st_nxt = S_CLEAR;
          end
        end
      end
      default: st_nxt = S_IDLE;
    endcase

    // Period and angle are latched on entry, using the level the new phase will run at.
    if (st_nxt == S_LOAD && st != S_LOAD) period_nxt = calc_period(level_nxt);
    if (st_nxt == S_AIM && st != S_AIM) angle_nxt = {2'b00, fr};

    if (st_nxt != st) cnt_nxt = 32'd0;
    else if (st == S_LOAD || st == S_LOST || st == S_WON) cnt_nxt = cnt + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= S_IDLE;
      level    <= 3'd0;
      lives    <= LIVES_INIT;
      angle    <= 3'd0;
      period   <= calc_period(3'd0);
      cnt      <= 32'd0;
      // Primed high so a button held across reset release is not seen as a press.
      start_q  <= 1'b1;
      launch_q <= 1'b1;
      fr       <= 1'b0;
    end else begin
      st       <= st_nxt;
      level    <= level_nxt;
      lives    <= lives_nxt;
      angle    <= angle_nxt;
      period   <= period_nxt;
      cnt      <= cnt_nxt;
      start_q  <= btn_start;
      launch_q <= btn_launch;
      fr       <= ~fr;
    end
  end

endmodule
